// File: rtl/sc_downtransition_timer.sv
// Loadable down-counting transition timer: loads a period, counts to zero, emits a one-cycle expiry tick.
// Optional macro SC_DOWNTRANSITION0_AUTORELOAD_EN turns the one-shot into a free-running periodic tick.
module sc_downtransition_timer #(
    parameter int DOWNTRANSITION_DATAWIDTH = 8
) (
    input  logic                                SC_upTRANSITIONCOUNTER0_CLOCK_50,
    input  logic                                SC_upTRANSITIONCOUNTER0_RESET_InHigh,
    input  logic                                SC_DOWNTRANSITION0_load_InLow,
    input  logic                                SC_DOWNTRANSITION0_downcount_InLow,
    input  logic [DOWNTRANSITION_DATAWIDTH-1:0] SC_DOWNTRANSITION0_data_InBUS,
    output logic [DOWNTRANSITION_DATAWIDTH-1:0] SC_DOWNTRANSITION0_data_OutBUS,
    output logic                                SC_DOWNTRANSITION0_tick_OutHigh,
    output logic                                SC_DOWNTRANSITION0_busy_OutHigh
);

    localparam logic [1:0] STATE_IDLE   = 2'd0;
    localparam logic [1:0] STATE_COUNT  = 2'd1;
    localparam logic [1:0] STATE_EXPIRE = 2'd2;

    localparam logic [DOWNTRANSITION_DATAWIDTH-1:0] COUNT_ZERO = '0;
    localparam logic [DOWNTRANSITION_DATAWIDTH-1:0] COUNT_ONE  = {{(DOWNTRANSITION_DATAWIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                          state;
    logic [1:0]                          stateNext;
    logic [DOWNTRANSITION_DATAWIDTH-1:0] count;
    logic [DOWNTRANSITION_DATAWIDTH-1:0] countNext;
    logic [DOWNTRANSITION_DATAWIDTH-1:0] period;
    logic [DOWNTRANSITION_DATAWIDTH-1:0] periodNext;

    function automatic logic [DOWNTRANSITION_DATAWIDTH-1:0] decrementCount(
        input logic [DOWNTRANSITION_DATAWIDTH-1:0] value
    );
        return value - COUNT_ONE;
    endfunction

    // Load wins over everything else; the count==1 transition keeps the counter from wrapping.
    always_comb begin
        stateNext  = state;
        countNext  = count;
        periodNext = period;
        if (!SC_DOWNTRANSITION0_load_InLow) begin
            countNext  = SC_DOWNTRANSITION0_data_InBUS;
            periodNext = SC_DOWNTRANSITION0_data_InBUS;
            stateNext  = (SC_DOWNTRANSITION0_data_InBUS != COUNT_ZERO) ? STATE_COUNT : STATE_EXPIRE;
        end else begin
            case (state)
                STATE_IDLE: begin
                    stateNext = STATE_IDLE;
                end
                STATE_COUNT: begin
                    if (!SC_DOWNTRANSITION0_downcount_InLow) begin
                        if (count == COUNT_ONE) begin
                            countNext = COUNT_ZERO;
                            stateNext = STATE_EXPIRE;
                        end else begin
                            countNext = decrementCount(count);
                        end
                    end
                end
                STATE_EXPIRE: begin
`ifdef SC_DOWNTRANSITION0_AUTORELOAD_EN
                    // A zero period keeps the block parked in EXPIRE, ticking every cycle.
                    if (period != COUNT_ZERO) begin
                        countNext = period;
                        stateNext = STATE_COUNT;
                    end
`else
                    stateNext = STATE_IDLE;
`endif
                end
                default: begin
                    stateNext = STATE_IDLE;
                    countNext = COUNT_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge SC_upTRANSITIONCOUNTER0_CLOCK_50 or posedge SC_upTRANSITIONCOUNTER0_RESET_InHigh) begin
        if (SC_upTRANSITIONCOUNTER0_RESET_InHigh) begin
            state  <= STATE_IDLE;
            count  <= COUNT_ZERO;
            period <= COUNT_ZERO;
        end else begin
            state  <= stateNext;
            count  <= countNext;
            period <= periodNext;
        end
    end

    assign SC_DOWNTRANSITION0_data_OutBUS  = count;
    assign SC_DOWNTRANSITION0_tick_OutHigh = (state == STATE_EXPIRE);
    assign SC_DOWNTRANSITION0_busy_OutHigh = (state != STATE_IDLE);

endmodule

// File: tb/tb_sc_downtransition_timer.sv
// Scoreboard bench for sc_downtransition_timer: stimulus pushes model expectations, a monitor pops and compares.
module tb_sc_downtransition_timer;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tick;
        logic         busy;
    } expT;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         loadN = 1'b1;
    logic         dcN = 1'b1;
    logic [W-1:0] dataIn = '0;
    logic [W-1:0] dataOut;
    logic         tickOut;
    logic         busyOut;

    int compared = 0;
    int mismatched = 0;
    expT expQ[$];

    // Reference model state: remaining count, programmed period, armed and expiring flags.
    int mCnt = 0;
    int mPer = 0;
    bit mArmed = 0;
    bit mExpiring = 0;

    sc_downtransition_timer #(.DOWNTRANSITION_DATAWIDTH(W)) dut (
        .SC_upTRANSITIONCOUNTER0_CLOCK_50    (clk),
        .SC_upTRANSITIONCOUNTER0_RESET_InHigh(rst),
        .SC_DOWNTRANSITION0_load_InLow       (loadN),
        .SC_DOWNTRANSITION0_downcount_InLow  (dcN),
        .SC_DOWNTRANSITION0_data_InBUS       (dataIn),
        .SC_DOWNTRANSITION0_data_OutBUS      (dataOut),
        .SC_DOWNTRANSITION0_tick_OutHigh     (tickOut),
        .SC_DOWNTRANSITION0_busy_OutHigh     (busyOut)
    );

    always #5 clk = ~clk;

    function automatic expT modelOut();
        expT e;
        e.cnt  = mCnt[W-1:0];
        e.tick = mExpiring;
        e.busy = mArmed;
        return e;
    endfunction

    task automatic modelReset();
        mCnt = 0; mPer = 0; mArmed = 0; mExpiring = 0;
    endtask

    task automatic modelStep(input bit ld, input bit dc, input int d);
        if (!ld) begin
            mPer = d; mCnt = d; mArmed = 1; mExpiring = (d == 0);
        end else if (mExpiring) begin
`ifdef SC_DOWNTRANSITION0_AUTORELOAD_EN
            if (mPer != 0) begin
                mExpiring = 0; mCnt = mPer;
            end
`else
            mExpiring = 0; mArmed = 0;
`endif
        end else if (mArmed && !dc) begin
            mCnt = mCnt - 1;
            if (mCnt == 0) mExpiring = 1;
        end
    endtask

    task automatic checkNow(input string name, input expT e);
        compared++;
        if ({dataOut, tickOut, busyOut} !== e) begin
            mismatched++;
            $display("FAIL %s: got count=%0d tick=%0b busy=%0b, expected count=%0d tick=%0b busy=%0b",
                     name, dataOut, tickOut, busyOut, e.cnt, e.tick, e.busy);
        end
    endtask

    task automatic cycle(input bit ld, input bit dc, input logic [W-1:0] d);
        @(negedge clk);
        loadN = ld; dcN = dc; dataIn = d;
        modelStep(ld, dc, int'(d));
        expQ.push_back(modelOut());
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, $urandom_range(0, 255));
    endtask

    // Reset asserted mid low-phase; outputs must clear before the next rising edge.
    task automatic asyncReset();
        @(negedge clk);
        #2 rst = 1'b1; loadN = 1'b1; dcN = 1'b1;
        #1 modelReset();
        checkNow("async_reset", modelOut());
        expQ.push_back(modelOut());
        @(negedge clk);
        rst = 1'b0;
        modelStep(1'b1, 1'b1, 0);
        expQ.push_back(modelOut());
    endtask

    always begin
        @(posedge clk);
        #1;
        if (expQ.size() > 0) checkNow("cycle", expQ.pop_front());
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkNow("reset_state", '0);
        rst = 1'b0;
        modelStep(1'b1, 1'b1, 0);
        expQ.push_back(modelOut());

        cycle(1'b0, 1'b0, 8'd5);
        idleCycles(9);

        cycle(1'b0, 1'b0, 8'd4);
        cycle(1'b1, 1'b0, 8'd0);
        cycle(1'b1, 1'b0, 8'd0);
        repeat (3) cycle(1'b1, 1'b1, 8'd0);
        idleCycles(6);

        cycle(1'b0, 1'b1, 8'd0);
        idleCycles(3);

        cycle(1'b0, 1'b0, 8'd200);
        while (mCnt != 150) cycle(1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 8'd3);
        idleCycles(6);

        cycle(1'b0, 1'b0, 8'd1);
        repeat (4) cycle(1'b1, 1'b1, 8'd0);
        idleCycles(3);

        cycle(1'b0, 1'b0, 8'd255);
        while (mCnt != 100) cycle(1'b1, 1'b0, 8'd0);
        asyncReset();
        idleCycles(4);

        cycle(1'b0, 1'b0, 8'd255);
        idleCycles(260);

`ifdef SC_DOWNTRANSITION0_AUTORELOAD_EN
        cycle(1'b0, 1'b0, 8'd3);
        idleCycles(24);
        cycle(1'b0, 1'b0, 8'd0);
        idleCycles(5);
`endif

        for (int i = 0; i < 3000; i++) begin
            bit ld;
            bit dc;
            logic [W-1:0] d;
            ld = ($urandom_range(0, 19) != 0);
            dc = ($urandom_range(0, 3) == 0);
            d  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 12));
            if ($urandom_range(0, 499) == 0) asyncReset();
            else cycle(ld, dc, d);
        end

        @(negedge clk);
        loadN = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sc_downtransition_timer.md
Name: sc_downtransition_timer

Overview:
- Loadable down-counting transition timer.
- Converts a programmed cycle count into a single-cycle expiry tick, with pause and busy indication.
- Complement of the up-transition counter: it loads a period and counts toward zero instead of accumulating from zero.
- Drives game-timing events such as lane shifts and frog-move pacing.

Parameters:
DOWNTRANSITION_DATAWIDTH, 8, width of the period/count datapath in bits (>=2)

Ports:
SC_upTRANSITIONCOUNTER0_CLOCK_50  input  1  system clock, rising-edge
SC_upTRANSITIONCOUNTER0_RESET_InHigh  input  1  asynchronous, active-high reset
SC_DOWNTRANSITION0_load_InLow  input  1  active-low load strobe: capture period and start countdown
SC_DOWNTRANSITION0_downcount_InLow  input  1  active-low count enable; high = pause
SC_DOWNTRANSITION0_data_InBUS  input  DOWNTRANSITION_DATAWIDTH  period value N
SC_DOWNTRANSITION0_data_OutBUS  output  DOWNTRANSITION_DATAWIDTH  current count register
SC_DOWNTRANSITION0_tick_OutHigh  output  1  one-cycle expiry pulse
SC_DOWNTRANSITION0_busy_OutHigh  output  1  high while the timer is armed (COUNT or EXPIRE)

Behaviour:
- Reset: SC_upTRANSITIONCOUNTER0_RESET_InHigh is asynchronous and active-high; clock is SC_upTRANSITIONCOUNTER0_CLOCK_50.
  - Reset forces state=IDLE, count=0, period register=0.
  - data_OutBUS=0, tick_OutHigh=0, busy_OutHigh=0.
  - Asserting reset mid-count aborts immediately; no tick is produced.
- States: IDLE, COUNT, EXPIRE. All outputs are registered or state-decoded (Moore); no combinational path from inputs to outputs.
- Load has priority over decrement in every state:
  - load_InLow=0 at an edge sets count<=data_InBUS and period<=data_InBUS.
  - Next state is COUNT if data_InBUS!=0, else EXPIRE.
- IDLE:
  - count holds.
  - busy=0, tick=0.
  - downcount_InLow is ignored.
- COUNT:
  - When downcount_InLow=0 and no load: count<=count-1.
  - If count==1 at that edge, count<=0 and next state is EXPIRE.
  - When downcount_InLow=1: count and state hold (pause).
  - busy=1, tick=0.
- EXPIRE:
  - tick=1, busy=1, for exactly one cycle.
  - Next edge with no load: IDLE, count stays 0.
  - Load during EXPIRE: the tick for this cycle is still emitted, the new value is loaded, and the next state follows the load rule.
- Latency with load value N>=1 and enable held low:
  - The load edge is edge 0, leaving count=N.
  - Edges 1..N decrement the count.
  - tick is high in the cycle after edge N.
  - Load to tick = N+1 clock edges.
- Load value 0: tick is asserted in the cycle after the load edge.
- Arithmetic:
  - Unsigned, modulo 2^W.
  - count never decrements below 0, because the transition at count==1 prevents wrap.
  - N = 2^W-1 is legal.
- Simultaneous load=0 and downcount=0: the load wins and no decrement occurs that edge.
- Pausing in COUNT at count==1 holds indefinitely with no tick.

Optional Feature:
Macro SC_DOWNTRANSITION0_AUTORELOAD_EN.
- Defined:
  - EXPIRE with no load goes to COUNT with count<=period (period!=0), giving a free-running tick every N+1 cycles while enabled.
  - If period==0, the block stays in EXPIRE and tick is high every cycle.
  - busy stays 1 until reset.
  - A new load replaces the period.
- Undefined: one-shot behaviour exactly as in Behaviour; no period-reload path is synthesized.

Test Plan:
- Reset, then load 5 with enable low -> data_OutBUS 5,4,3,2,1,0 on successive edges; tick=1 for exactly one cycle 6 edges after the load; then IDLE with busy=0.
- Load 4, raise downcount_InLow for 3 cycles when count=2 -> count holds at 2 for 3 cycles, resumes; tick is delayed by exactly 3 cycles versus the unpaused run.
- Load 0 -> tick=1 in the cycle after the load edge; busy=1 for that cycle only; count=0.
- Load 200, reassert load with 3 when count=150 (load and downcount both low) -> count=3 next edge with no decrement; tick follows after 3 more decrements.
- Load 255, assert reset asynchronously mid-count at count=100 -> all outputs 0 immediately, before the next clock; no tick.
- With SC_DOWNTRANSITION0_AUTORELOAD_EN, load 3 -> tick pulses repeat every 4 cycles for at least 5 periods; data_OutBUS sequence is 3,2,1,0,3,2,1,0…
